cv32e41p_wb_arbiter: RTL

- Writeback arbiter directly upstream of the integer/FP register file; drives its two write ports (A and B).
- Merges three result producers into the two ports:
  - ALU/EX: single-cycle, fixed to port A.
  - LSU load return: fixed to port B.
  - Multi-cycle MDU: takes whichever port is free.
- Buffers MDU results when both ports are busy and squashes stale buffered writes (WAW).
- Optionally provides bypass data for writes not yet committed.

---
 rtl/cv32e41p_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cv32e41p_wb_arbiter.sv
// Writeback arbiter: merges ALU, LSU and MDU results onto the two register-file write ports.
// Optional bypass lookup is built when CV32E41P_WB_BYPASS_EN is defined.
module cv32e41p_wb_arbiter #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_we_i,
   input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
   input  logic [DATA_WIDTH-1:0] alu_wdata_i,
   input  logic                  lsu_we_i,
   input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
   input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
   input  logic                  mdu_valid_i,
   output logic                  mdu_ready_o,
   input  logic [ADDR_WIDTH-1:0] mdu_waddr_i,
   input  logic [DATA_WIDTH-1:0] mdu_wdata_i,
   output logic                  we_a_o,
   output logic [ADDR_WIDTH-1:0] waddr_a_o,
   output logic [DATA_WIDTH-1:0] wdata_a_o,
   output logic                  we_b_o,
   output logic [ADDR_WIDTH-1:0] waddr_b_o,
   output logic [DATA_WIDTH-1:0] wdata_b_o,
   input  logic [ADDR_WIDTH-1:0] raddr_a_i,
   input  logic [ADDR_WIDTH-1:0] raddr_b_i,
   input  logic [ADDR_WIDTH-1:0] raddr_c_i,
   output logic                  byp_hit_a_o,
   output logic                  byp_hit_b_o,
   output logic                  byp_hit_c_o,
   output logic [DATA_WIDTH-1:0] byp_data_a_o,
   output logic [DATA_WIDTH-1:0] byp_data_b_o,
   output logic [DATA_WIDTH-1:0] byp_data_c_o,
   output logic                  busy_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
      int s;
      s = (int'(p) + k) % DEPTH;
      return PTR_W'(s);
   endfunction

   logic [ADDR_WIDTH-1:0] buf_addr [DEPTH];
   logic [DATA_WIDTH-1:0] buf_data [DEPTH];
   logic [DEPTH-1:0]      buf_valid;
   logic [PTR_W-1:0]      head_q;
   logic [CNT_W-1:0]      count_q;

   logic                  we_a_q, we_b_q;
   logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_b_q;
   logic [DATA_WIDTH-1:0] wdata_a_q, wdata_b_q;

   logic                  alu_iss, lsu_iss;
   logic [DEPTH-1:0]      squash, pop_mask;
   logic                  a_left, b_left, stop;
   logic [CNT_W-1:0]      n_pop;
   logic                  drn_a, drn_b;
   logic [PTR_W-1:0]      drn_a_slot, drn_b_slot, slot, wr_slot;
   logic                  all_drained, mdu_acc, mdu_live;
   logic                  mdu_to_a, mdu_to_b, mdu_enq;

   logic                  we_a_d, we_b_d;
   logic [ADDR_WIDTH-1:0] waddr_a_d, waddr_b_d;
   logic [DATA_WIDTH-1:0] wdata_a_d, wdata_b_d;

   assign alu_iss = alu_we_i && (alu_waddr_i != '0);
   assign lsu_iss = lsu_we_i && (lsu_waddr_i != '0);

   // WAW: an ALU/LSU write supersedes any older buffered MDU write to the same register.
   always_comb begin
      squash = '0;
      for (int s = 0; s < DEPTH; s++) begin
         if (buf_valid[s] && ((alu_iss && (buf_addr[s] == alu_waddr_i)) ||
                              (lsu_iss && (buf_addr[s] == lsu_waddr_i))))
            squash[s] = 1'b1;
      end
   end

   // Walk the FIFO from the head: dead entries pop for free, live ones need a free port.
   always_comb begin
      a_left     = !alu_iss;
      b_left     = !lsu_iss;
      stop       = 1'b0;
      n_pop      = '0;
      pop_mask   = '0;
      drn_a      = 1'b0;
      drn_b      = 1'b0;
      drn_a_slot = '0;
      drn_b_slot = '0;
      slot       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = ptr_add(head_q, k);
         if (!stop && (k < int'(count_q))) begin
            if (!buf_valid[slot] || squash[slot]) begin
               pop_mask[slot] = 1'b1;
               n_pop          = n_pop + CNT_W'(1);
            end else if (a_left) begin
               drn_a          = 1'b1;
               drn_a_slot     = slot;
               a_left         = 1'b0;
               pop_mask[slot] = 1'b1;
               n_pop          = n_pop + CNT_W'(1);
            end else if (b_left) begin
               drn_b          = 1'b1;
               drn_b_slot     = slot;
               b_left         = 1'b0;
               pop_mask[slot] = 1'b1;
               n_pop          = n_pop + CNT_W'(1);
            end else begin
               stop = 1'b1;
            end
         end
      end
   end

   assign all_drained = (n_pop == count_q);
   assign wr_slot     = ptr_add(head_q, int'(count_q));
   assign mdu_ready_o = rst_n && ((count_q != CNT_W'(DEPTH)) || (n_pop != '0));
   assign mdu_acc     = mdu_valid_i && mdu_ready_o;
   assign mdu_live    = mdu_acc && (mdu_waddr_i != '0) &&
                        !(alu_iss && (mdu_waddr_i == alu_waddr_i)) &&
                        !(lsu_iss && (mdu_waddr_i == lsu_waddr_i));
   // A fresh result may only bypass the buffer once every older entry has left it.
   assign mdu_to_a    = mdu_live && all_drained && a_left;
   assign mdu_to_b    = mdu_live && all_drained && !a_left && b_left;
   assign mdu_enq     = mdu_live && !mdu_to_a && !mdu_to_b;

   always_comb begin
      we_a_d    = 1'b0;
      waddr_a_d = '0;
      wdata_a_d = '0;
      if (alu_iss) begin
         we_a_d    = 1'b1;
         waddr_a_d = alu_waddr_i;
         wdata_a_d = alu_wdata_i;
      end else if (drn_a) begin
         we_a_d    = 1'b1;
         waddr_a_d = buf_addr[drn_a_slot];
         wdata_a_d = buf_data[drn_a_slot];
      end else if (mdu_to_a) begin
         we_a_d    = 1'b1;
         waddr_a_d = mdu_waddr_i;
         wdata_a_d = mdu_wdata_i;
      end
   end

   always_comb begin
      we_b_d    = 1'b0;
      waddr_b_d = '0;
      wdata_b_d = '0;
      if (lsu_iss) begin
         we_b_d    = 1'b1;
         waddr_b_d = lsu_waddr_i;
         wdata_b_d = lsu_wdata_i;
      end else if (drn_b) begin
         we_b_d    = 1'b1;
         waddr_b_d = buf_addr[drn_b_slot];
         wdata_b_d = buf_data[drn_b_slot];
      end else if (mdu_to_b) begin
         we_b_d    = 1'b1;
         waddr_b_d = mdu_waddr_i;
         wdata_b_d = mdu_wdata_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_a_q    <= 1'b0;
         waddr_a_q <= '0;
         wdata_a_q <= '0;
         we_b_q    <= 1'b0;
         waddr_b_q <= '0;
         wdata_b_q <= '0;
      end else begin
         we_a_q    <= we_a_d;
         waddr_a_q <= waddr_a_d;
         wdata_a_q <= wdata_a_d;
         we_b_q    <= we_b_d;
         waddr_b_q <= waddr_b_d;
         wdata_b_q <= wdata_b_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q    <= '0;
         count_q   <= '0;
         buf_valid <= '0;
      end else begin
         head_q    <= ptr_add(head_q, int'(n_pop));
         count_q   <= count_q - n_pop + CNT_W'(mdu_enq);
         for (int s = 0; s < DEPTH; s++) begin
            if (mdu_enq && (wr_slot == PTR_W'(s)))
               buf_valid[s] <= 1'b1;
            else if (squash[s] || pop_mask[s])
               buf_valid[s] <= 1'b0;
         end
      end
   end

   // NOTE: payload storage is not reset; buf_valid and count_q alone decide what is live.
   always_ff @(posedge clk) begin
      if (mdu_enq) begin
         buf_addr[wr_slot] <= mdu_waddr_i;
         buf_data[wr_slot] <= mdu_wdata_i;
      end
   end

   assign we_a_o    = we_a_q;
   assign waddr_a_o = waddr_a_q;
   assign wdata_a_o = wdata_a_q;
   assign we_b_o    = we_b_q;
   assign waddr_b_o = waddr_b_q;
   assign wdata_b_o = wdata_b_q;
   assign busy_o    = (count_q != '0) || we_a_q || we_b_q;

`ifdef CV32E41P_WB_BYPASS_EN
   logic [ADDR_WIDTH-1:0] byp_raddr [3];
   logic [2:0]            byp_hit;
   logic [DATA_WIDTH-1:0] byp_data [3];
   logic [PTR_W-1:0]      bslot;

   assign byp_raddr[0] = raddr_a_i;
   assign byp_raddr[1] = raddr_b_i;
   assign byp_raddr[2] = raddr_c_i;

   // Later assignments win: newest buffer entry, then port A, then port B.
   always_comb begin
      byp_hit = '0;
      bslot   = '0;
      for (int p = 0; p < 3; p++) begin
         byp_data[p] = '0;
         for (int k = 0; k < DEPTH; k++) begin
            bslot = ptr_add(head_q, k);
            if ((k < int'(count_q)) && buf_valid[bslot] && (buf_addr[bslot] == byp_raddr[p])) begin
               byp_hit[p]  = 1'b1;
               byp_data[p] = buf_data[bslot];
            end
         end
         if (we_a_q && (waddr_a_q == byp_raddr[p])) begin
            byp_hit[p]  = 1'b1;
            byp_data[p] = wdata_a_q;
         end
         if (we_b_q && (waddr_b_q == byp_raddr[p])) begin
            byp_hit[p]  = 1'b1;
            byp_data[p] = wdata_b_q;
         end
         if (byp_raddr[p] == '0) begin
            byp_hit[p]  = 1'b0;
            byp_data[p] = '0;
         end
      end
   end

   assign byp_hit_a_o  = byp_hit[0];
   assign byp_hit_b_o  = byp_hit[1];
   assign byp_hit_c_o  = byp_hit[2];
   assign byp_data_a_o = byp_data[0];
   assign byp_data_b_o = byp_data[1];
   assign byp_data_c_o = byp_data[2];
`else
   logic unused_raddr;
   assign unused_raddr = ^{raddr_a_i, raddr_b_i, raddr_c_i};

   assign byp_hit_a_o  = 1'b0;
   assign byp_hit_b_o  = 1'b0;
   assign byp_hit_c_o  = 1'b0;
   assign byp_data_a_o = '0;
   assign byp_data_b_o = '0;
   assign byp_data_c_o = '0;
`endif

endmodule
